// File: rtl/wb_pkg.sv
// Shared widths and FSM state type for the core-to-Wishbone bridge.
package wb_pkg;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SELW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
endpackage

// File: rtl/wb_txn_fifo.sv
// Small FIFO that remembers the write flag of each outstanding transaction.
module wb_txn_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/core_to_wb.sv
// Core req/gnt/rvalid to Wishbone B4 pipelined master bridge with
// bounded outstanding transactions and a response timeout abort.
module core_to_wb
    import wb_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic            we_i,
    input  logic [SELW-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [AW-1:0]   adr_o,
    output logic [SELW-1:0] sel_o,
    output logic [DW-1:0]   dat_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            stall_i
);
    localparam int unsigned   CW      = $clog2(MAX_OUT + 1);
    localparam int unsigned   TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;
    logic          w_open;
    logic          w_issue;
    logic          w_bus_resp;
    logic          w_abort_resp;
    logic          w_pop;
    logic          w_head_we;
    logic          w_full;
    logic          w_empty;

    assign adr_o = addr_i;
    assign sel_o = be_i;
    assign we_o  = we_i;
    assign dat_o = wdata_i;

    // Gating with rst_ni keeps the handshake outputs low for the whole reset.
    assign w_open       = rst_ni & (r_state != ABORT);
    assign stb_o        = w_open & req_i & (r_cnt < MAX_CNT) & ~w_full;
    assign gnt_o        = stb_o & ~stall_i;
    assign cyc_o        = w_open & (stb_o | (r_cnt != '0));
    assign w_issue      = gnt_o;
    assign w_bus_resp   = w_open & (ack_i | err_i) & (r_cnt != '0) & ~w_empty;
    assign w_abort_resp = rst_ni & (r_state == ABORT) & (r_cnt != '0);
    assign w_pop        = w_bus_resp | w_abort_resp;

    assign rvalid_o = w_pop;
    assign err_o    = w_abort_resp | (w_bus_resp & err_i);
    assign rdata_o  = (w_bus_resp & ~w_head_we) ? dat_i : '0;

    wb_txn_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (1)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_issue),
        .i_pop   (w_pop),
        .i_data  (we_i),
        .o_data  (w_head_we),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_issue && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_issue && w_pop) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end

        w_tmo_nxt = '0;
        if ((r_state == BUSY) && !w_issue && !ack_i && !err_i && (r_cnt != '0)) begin
            w_tmo_nxt = r_tmo + TW'(1);
        end

        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_state_nxt = BUSY;
            BUSY: begin
                if (r_tmo == TMO_LIM) begin
                    w_state_nxt = ABORT;
                end else if (w_cnt_nxt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            // The last synthesized response is emitted in the same cycle we leave.
            ABORT:   if (r_cnt <= CW'(1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end
endmodule

// File: doc/core_to_wb.md
CORE_TO_WB -- requirements
Module: core_to_wb

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, giving the maximum number of outstanding Wishbone transactions (range 1..4).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the number of cycles without ack/err before a bus abort.
REQ-003 SHALL have ports, in order:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_i  in  1  core request.
- gnt_o  out  1  request accepted.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  response error.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write.
- adr_o  out  32  Wishbone address.
- sel_o  out  4  Wishbone select.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data.
- ack_i  in  1  Wishbone ack.
- err_i  in  1  Wishbone error.
- stall_i  in  1  Wishbone stall.
REQ-004 SHALL use one clock, clk_i; rst_ni SHALL be asynchronous and active-low.

Function
REQ-005 SHALL implement a Wishbone B4 pipelined master fed by the core req/gnt/rvalid interface.
REQ-006 SHALL drive adr_o, sel_o, we_o and dat_o combinationally from addr_i, be_i, we_i and wdata_i.
REQ-007 SHALL assert stb_o = req_i & (cnt < MAX_OUT) & (state == BUSY or IDLE).
REQ-008 SHALL assert gnt_o = stb_o & ~stall_i; issue occurs in any cycle with gnt_o high.
REQ-009 SHALL hold cyc_o high whenever stb_o is high or cnt != 0, except in ABORT.
REQ-010 SHALL keep counter cnt: +1 on issue; -1 on ack_i|err_i while cnt != 0; unchanged on simultaneous issue and response.
REQ-011 SHALL push we_i into the transaction FIFO on issue and pop it on each response.
REQ-012 SHALL produce the core response in the same cycle as ack_i|err_i when cnt != 0: rvalid_o=1, err_o=err_i.
REQ-013 SHALL drive rdata_o = dat_i for read responses and 32'h0 for write responses and for all non-response cycles.
REQ-014 SHALL treat ack_i and err_i both high as an error response.
REQ-015 SHALL ignore ack_i/err_i when cnt == 0, with no rvalid_o and no counter underflow.
REQ-016 SHALL run an FSM with the following states and transitions:
- IDLE (cnt == 0): moves to BUSY on issue.
- BUSY: returns to IDLE when cnt reaches 0; moves to ABORT when the timeout counter reaches TIMEOUT.
- ABORT: drains, then returns to IDLE.
REQ-017 SHALL run a timeout counter that is cleared on any issue, ack_i or err_i, or when cnt == 0, and otherwise increments in BUSY.
REQ-018 In ABORT, SHALL drive cyc_o=0, stb_o=0 and gnt_o=0, and ignore ack_i/err_i.
REQ-019 In ABORT, SHALL emit one synthesized response per cycle (rvalid_o=1, err_o=1, rdata_o=0), popping the FIFO, until cnt == 0, then go to IDLE.
REQ-020 SHALL keep the ABORT response cycle count exactly equal to cnt at ABORT entry.

Reset
REQ-021 On rst_ni low, SHALL asynchronously clear cnt, the timeout counter and the FIFO, and set state=IDLE.
REQ-022 During reset, SHALL hold gnt_o, rvalid_o, err_o, cyc_o and stb_o at 0 and rdata_o at 0.
REQ-023 Reset mid-transaction SHALL discard all outstanding transactions silently, with no response generated.

Structure
REQ-024 Package wb_pkg SHALL hold the widths AW=32, DW=32, SELW=4 and the state enum {IDLE, BUSY, ABORT}.
REQ-025 The write-flag FIFO SHALL be sub-module wb_txn_fifo: depth MAX_OUT, width 1, with push, pop, full, empty, and an asynchronous active-low reset.

Verification
REQ-026 Single read: addr_i=0x100, ack_i one cycle after issue with dat_i=0xDEADBEEF -> gnt_o=1 for 1 cycle; rvalid_o=1 and rdata_o=0xDEADBEEF the next cycle; cyc_o then drops.
REQ-027 Back-to-back: write then read with stall_i=0 and acks delayed 2 cycles -> cnt reaches 2 and a third req_i is not granted; responses in order, rdata_o=0 for the write.
REQ-028 Stall: stall_i=1 for 3 cycles with req_i=1 -> gnt_o=0 for those 3 cycles, then gnt_o=1; cnt does not change while stalled.
REQ-029 Timeout: 2 issued, no ack for TIMEOUT cycles -> ABORT with cyc_o=0, then exactly 2 rvalid_o cycles with err_o=1; a late ack_i is ignored.
REQ-030 Edge cases: ack_i with err_i=1 -> err_o=1; a stray ack_i at cnt=0 -> no rvalid_o; rst_ni pulsed low with cnt=1 -> all outputs 0 immediately and no response afterwards.
